// File: rtl/alu_mc_sequencer.sv
// Multi-cycle ALU sequencer for the EX stage: classifies the issuing op, stalls the
// pipeline for the op's latency, then signals result-valid with a saturating stall counter.

package alu_mc_pkg;
   typedef enum logic [4:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
      ALU_SLT, ALU_SLTU, ALU_MUL, ALU_MULH, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
      ALU_F_ADD, ALU_F_SUB, ALU_F_INT_FLOAT, ALU_F_FLOAT_INT
   } alu_op_t;
endpackage

module alu_mc_sequencer
   import alu_mc_pkg::*;
#(
   parameter int LAT_FCVT = 1,
   parameter int LAT_FADD = 2,
   parameter int LAT_MUL  = 6,
   parameter int LAT_LONG = 32,
   parameter int CNT_W    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  alu_op_t       alu_op,
   input  logic          op_valid,
   input  logic          flush,
   input  logic          hold,
   output logic          insert_bubble,
   output logic          op_done,
   output logic [2:0]    busy_class,
   output logic [31:0]   stall_cycles
);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

   localparam logic [CNT_W-1:0] L_FCVT = CNT_W'(LAT_FCVT);
   localparam logic [CNT_W-1:0] L_FADD = CNT_W'(LAT_FADD);
   localparam logic [CNT_W-1:0] L_MUL  = CNT_W'(LAT_MUL);
   localparam logic [CNT_W-1:0] L_LONG = CNT_W'(LAT_LONG);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [2:0]         r_busyClass;
   logic [31:0]        r_stallCycles;

   logic [CNT_W-1:0]   w_lat;
   logic [2:0]         w_class;
   logic               w_start;

   // A zero latency marks a single-cycle op that never engages the sequencer.
   always_comb begin
      w_lat   = '0;
      w_class = 3'b000;
      case (alu_op)
         ALU_F_FLOAT_INT: begin w_lat = L_FCVT; w_class = 3'b001; end
         ALU_F_ADD,
         ALU_F_SUB:       begin w_lat = L_FADD; w_class = 3'b001; end
         ALU_MUL,
         ALU_MULH:        begin w_lat = L_MUL;  w_class = 3'b010; end
         ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
         ALU_F_INT_FLOAT: begin w_lat = L_LONG; w_class = 3'b100; end
         default:         begin w_lat = '0;     w_class = 3'b000; end
      endcase
   end

   assign w_start       = (r_state == ST_IDLE) & op_valid & (w_lat != '0) & ~flush;
   assign insert_bubble = rst & ~flush & (w_start | (r_state == ST_BUSY));
   assign op_done       = rst & ~flush & (r_state == ST_DONE);
   assign busy_class    = r_busyClass;
   assign stall_cycles  = r_stallCycles;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_busyClass <= 3'b000;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_busyClass <= w_class;
                  r_cnt       <= w_lat - ONE;
                  r_state     <= (w_lat == ONE) ? ST_DONE : ST_BUSY;
               end
            end
            // hold is deliberately ignored here: the execution units keep running.
            ST_BUSY: begin
               if (flush) begin
                  r_state     <= ST_IDLE;
                  r_cnt       <= '0;
                  r_busyClass <= 3'b000;
               end else if (r_cnt == ONE) begin
                  r_state <= ST_DONE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt - ONE;
               end
            end
            ST_DONE: begin
               if (flush || !hold) begin
                  r_state     <= ST_IDLE;
                  r_busyClass <= 3'b000;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_cnt       <= '0;
               r_busyClass <= 3'b000;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stallCycles <= '0;
      end else if (insert_bubble && (r_stallCycles != 32'hFFFF_FFFF)) begin
         r_stallCycles <= r_stallCycles + 32'd1;
      end
   end

endmodule

// File: tb/tb_alu_mc_sequencer.sv
// Self-checking bench for alu_mc_sequencer: directed scenarios plus randomized traffic,
// compared every cycle against a latency-timeline reference model.

module tb_alu_mc_sequencer;
   import alu_mc_pkg::*;

   localparam int LAT_FCVT = 1;
   localparam int LAT_FADD = 2;
   localparam int LAT_MUL  = 6;
   localparam int LAT_LONG = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   alu_op_t     aluOp = ALU_ADD;
   logic        opValid = 1'b0;
   logic        flush = 1'b0;
   logic        hold = 1'b0;
   logic        insertBubble;
   logic        opDone;
   logic [2:0]  busyClass;
   logic [31:0] stallCycles;

   int checkCount = 0;
   int errorCount = 0;

   // Model: bubble cycles still owed after the issue cycle, and whether a result is waiting.
   int          mBubblesLeft = 0;
   bit          mResultWaiting = 1'b0;
   logic [2:0]  mClass = 3'b000;
   logic [31:0] mStalls = 32'd0;

   alu_mc_sequencer #(
      .LAT_FCVT(LAT_FCVT), .LAT_FADD(LAT_FADD), .LAT_MUL(LAT_MUL),
      .LAT_LONG(LAT_LONG), .CNT_W(8)
   ) dut (
      .clk(clk), .rst(rst), .alu_op(aluOp), .op_valid(opValid), .flush(flush),
      .hold(hold), .insert_bubble(insertBubble), .op_done(opDone),
      .busy_class(busyClass), .stall_cycles(stallCycles)
   );

   always #5 clk = ~clk;

   function automatic int latOf(alu_op_t op);
      case (op)
         ALU_F_FLOAT_INT:                      return LAT_FCVT;
         ALU_F_ADD, ALU_F_SUB:                 return LAT_FADD;
         ALU_MUL, ALU_MULH:                    return LAT_MUL;
         ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
         ALU_F_INT_FLOAT:                      return LAT_LONG;
         default:                              return 0;
      endcase
   endfunction

   function automatic logic [2:0] classOf(alu_op_t op);
      case (op)
         ALU_F_FLOAT_INT, ALU_F_ADD, ALU_F_SUB:  return 3'b001;
         ALU_MUL, ALU_MULH:                      return 3'b010;
         ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
         ALU_F_INT_FLOAT:                        return 3'b100;
         default:                                return 3'b000;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // One clock cycle: drive inputs at the falling edge, check, then advance the model at the rising edge.
   task automatic applyStimulus(input alu_op_t op, input bit valid, input bit fl, input bit hd);
      bit idle, start, expBubble, expDone;
      @(negedge clk);
      aluOp = op; opValid = valid; flush = fl; hold = hd;
      #1;
      idle      = (mBubblesLeft == 0) && !mResultWaiting;
      start     = rst && idle && valid && (latOf(op) != 0) && !fl;
      expBubble = rst && !fl && (start || (mBubblesLeft > 0));
      expDone   = rst && !fl && mResultWaiting;
      checkOutput("insert_bubble", 32'(insertBubble), 32'(expBubble));
      checkOutput("op_done", 32'(opDone), 32'(expDone));
      checkOutput("busy_class", 32'(busyClass), 32'(rst ? mClass : 3'b000));
      checkOutput("stall_cycles", stallCycles, rst ? mStalls : 32'd0);
      @(posedge clk);
      if (!rst) begin
         mBubblesLeft = 0; mResultWaiting = 1'b0; mClass = 3'b000; mStalls = 32'd0;
      end else begin
         if (expBubble && (mStalls != 32'hFFFF_FFFF)) mStalls = mStalls + 32'd1;
         if (start) begin
            mClass = classOf(op);
            if (latOf(op) == 1) mResultWaiting = 1'b1;
            else                mBubblesLeft   = latOf(op) - 1;
         end else if (mBubblesLeft > 0) begin
            if (fl) begin
               mBubblesLeft = 0; mClass = 3'b000;
            end else begin
               mBubblesLeft--;
               if (mBubblesLeft == 0) mResultWaiting = 1'b1;
            end
         end else if (mResultWaiting && (fl || !hd)) begin
            mResultWaiting = 1'b0; mClass = 3'b000;
         end
      end
   endtask

   task automatic runOp(input alu_op_t op, input int n, input int flushAt, input int holdFrom, input int holdTo);
      for (int i = 0; i < n; i++)
         applyStimulus(op, 1'b1, i == flushAt, (i >= holdFrom) && (i <= holdTo));
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(ALU_ADD, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic checkStalls(input string tag, input logic [31:0] expected);
      #1;
      checkOutput(tag, stallCycles, expected);
   endtask

   task automatic asyncResetMidCycle();
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      checkOutput("rst_bubble", 32'(insertBubble), 32'd0);
      checkOutput("rst_done", 32'(opDone), 32'd0);
      checkOutput("rst_class", 32'(busyClass), 32'd0);
      checkOutput("rst_stalls", stallCycles, 32'd0);
      mBubblesLeft = 0; mResultWaiting = 1'b0; mClass = 3'b000; mStalls = 32'd0;
      @(posedge clk);
   endtask

   task automatic releaseReset();
      @(negedge clk);
      opValid = 1'b0; flush = 1'b0; hold = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("release_bubble", 32'(insertBubble), 32'd0);
      @(posedge clk);
   endtask

   initial begin
      applyStimulus(ALU_MUL, 1'b1, 1'b0, 1'b0);
      applyStimulus(ALU_DIV, 1'b1, 1'b0, 1'b0);
      releaseReset();

      runOp(ALU_MUL, 7, -1, -1, -1);
      idleCycles(2);
      checkStalls("mul_stalls", 32'd6);

      runOp(ALU_DIV, 33, -1, -1, -1);
      runOp(ALU_F_ADD, 3, -1, -1, -1);
      idleCycles(2);
      checkStalls("div_fadd_stalls", 32'd40);

      runOp(ALU_F_FLOAT_INT, 2, -1, -1, -1);
      runOp(ALU_ADD, 4, -1, -1, -1);
      idleCycles(1);
      checkStalls("fcvt_add_stalls", 32'd41);

      runOp(ALU_REMU, 11, 10, -1, -1);
      idleCycles(2);
      checkStalls("remu_flush_stalls", 32'd51);

      runOp(ALU_MULH, 9, -1, 6, 8);
      idleCycles(2);
      checkStalls("mulh_hold_stalls", 32'd57);

      runOp(ALU_F_INT_FLOAT, 5, -1, -1, -1);
      asyncResetMidCycle();
      applyStimulus(ALU_F_INT_FLOAT, 1'b1, 1'b0, 1'b0);
      releaseReset();
      runOp(ALU_MUL, 7, -1, -1, -1);
      idleCycles(2);
      checkStalls("post_reset_mul_stalls", 32'd6);

      for (int i = 0; i < 1500; i++) begin
         applyStimulus(alu_op_t'(5'($urandom_range(0, 19))),
                       $urandom_range(0, 99) < 70,
                       $urandom_range(0, 99) < 4,
                       $urandom_range(0, 99) < 30);
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
